// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM arbiter: FSM states, requester ids
// and the round-robin pick helper used by both the write and read ports.
package ram_arb_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // The pointer names the requester that wins a tie; a lone contender always wins.
    function automatic logic pick(input logic c0, input logic c1, input logic prio);
        logic id;
        if (c0 && c1) begin
            id = prio;
        end else if (c0) begin
            id = REQ0;
        end else begin
            id = REQ1;
        end
        return id;
    endfunction

endpackage

// File: rtl/RAM_param.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module RAM_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3072,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Only the output register is reset; the array is re-zeroed by the arbiter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= mem[i_raddr];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a shared RAM, with a clear sequencer that
// zeroes every word after reset or on request before arbitration starts.
//
//   state | meaning
//   CLEAR | writing 0 to one word per cycle, requests ignored
//   RUN   | independent round-robin arbitration of write and read ports
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3072,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_we0,
    input  logic                  i_we1,
    input  logic [ADDR_W-1:0]     i_addr0,
    input  logic [ADDR_W-1:0]     i_addr1,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_init_done
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    state_t state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic wr_prio, rd_prio;

    logic wr_c0, wr_c1, rd_c0, rd_c1;
    logic wr_fire, rd_fire;
    logic wr_id, rd_id;

    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_re;
    logic [ADDR_W-1:0]     ram_raddr;

    assign wr_c0 = i_req0 & i_we0;
    assign wr_c1 = i_req1 & i_we1;
    assign rd_c0 = i_req0 & ~i_we0;
    assign rd_c1 = i_req1 & ~i_we1;

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        wr_fire     = 1'b0;
        rd_fire     = 1'b0;
        wr_id       = REQ0;
        rd_id       = REQ0;
        ram_we      = 1'b0;
        ram_waddr   = clr_cnt;
        ram_wdata   = '0;
        ram_re      = 1'b0;
        ram_raddr   = i_addr0;

        case (state)
            CLEAR: begin
                ram_we = 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state_nxt   = RUN;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end
            RUN: begin
                if (wr_c0 || wr_c1) begin
                    wr_fire   = 1'b1;
                    wr_id     = pick(wr_c0, wr_c1, wr_prio);
                    ram_we    = 1'b1;
                    ram_waddr = (wr_id == REQ0) ? i_addr0 : i_addr1;
                    ram_wdata = (wr_id == REQ0) ? i_data0 : i_data1;
                end
                if (rd_c0 || rd_c1) begin
                    rd_fire   = 1'b1;
                    rd_id     = pick(rd_c0, rd_c1, rd_prio);
                    ram_re    = 1'b1;
                    ram_raddr = (rd_id == REQ0) ? i_addr0 : i_addr1;
                end
                // Grants of this cycle still complete; the clear starts next cycle.
                if (i_clear) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    assign o_gnt0      = (wr_fire && (wr_id == REQ0)) || (rd_fire && (rd_id == REQ0));
    assign o_gnt1      = (wr_fire && (wr_id == REQ1)) || (rd_fire && (rd_id == REQ1));
    assign o_init_done = (state == RUN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Tie pointers move away from whoever just won, only on a granting cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_prio <= REQ0;
            rd_prio <= REQ0;
        end else begin
            if (wr_fire) begin
                wr_prio <= ~wr_id;
            end
            if (rd_fire) begin
                rd_prio <= ~rd_id;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rvalid0 <= 1'b0;
            o_rvalid1 <= 1'b0;
        end else begin
            o_rvalid0 <= rd_fire && (rd_id == REQ0);
            o_rvalid1 <= rd_fire && (rd_id == REQ1);
        end
    end

    RAM_param #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (ram_we),
        .i_waddr (ram_waddr),
        .i_wdata (ram_wdata),
        .i_re    (ram_re),
        .i_raddr (ram_raddr),
        .o_rdata (o_rdata)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter (DEPTH=16): directed vector table, clear/reset
// sequences and a randomized run checked against a behavioural model.
module tb_ram_arbiter;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, clear;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic          gnt0, gnt1, rvalid0, rvalid1, init_done;
    logic [DW-1:0] rdata;

    int n_cmp = 0;
    int n_bad = 0;

    ram_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clear     (clear),
        .i_req0      (req0),
        .i_req1      (req1),
        .i_we0       (we0),
        .i_we1       (we1),
        .i_addr0     (addr0),
        .i_addr1     (addr1),
        .i_data0     (data0),
        .i_data1     (data1),
        .o_gnt0      (gnt0),
        .o_gnt1      (gnt1),
        .o_rvalid0   (rvalid0),
        .o_rvalid1   (rvalid1),
        .o_rdata     (rdata),
        .o_init_done (init_done)
    );

    // Behavioural model: clear countdown, word array, tie winner per port.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_clear_left;
    int            m_wprio, m_rprio;
    bit            m_rv0, m_rv1;
    logic [DW-1:0] m_rdata;
    int            m_ww, m_rw;

    typedef struct {
        bit            r0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        bit            r1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        bit            g0, g1, v0, v1;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(bit r0, bit w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                                bit r1, bit w1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                                bit g0, bit g1, bit v0, bit v1, logic [DW-1:0] rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(bit c0, bit c1, int prio);
        if (c0 && c1) return prio;
        if (c0) return 0;
        if (c1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_clear_left = DEPTH;
        m_wprio      = 0;
        m_rprio      = 0;
        m_rv0        = 1'b0;
        m_rv1        = 1'b0;
        m_rdata      = '0;
        m_ww         = -1;
        m_rw         = -1;
    endtask

    task automatic set_idle();
        req0 = 0; we0 = 0; addr0 = '0; data0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; data1 = '0;
        clear = 0;
    endtask

    // Entered at a negedge with inputs driven; returns at the next negedge.
    task automatic do_cycle(bit use_model);
        bit run;
        run  = (m_clear_left == 0);
        m_ww = run ? winner(req0 && we0, req1 && we1, m_wprio) : -1;
        m_rw = run ? winner(req0 && !we0, req1 && !we1, m_rprio) : -1;
        #1;
        if (use_model) begin
            chk("gnt0", gnt0, (m_ww == 0) || (m_rw == 0));
            chk("gnt1", gnt1, (m_ww == 1) || (m_rw == 1));
            chk("rvalid0", rvalid0, m_rv0);
            chk("rvalid1", rvalid1, m_rv1);
            chk("rdata", rdata, m_rdata);
            chk("init_done", init_done, run);
        end
        @(posedge clk);
        if (m_rw >= 0) begin
            m_rdata = m_mem[(m_rw == 0) ? addr0 : addr1];
            m_rv0   = (m_rw == 0);
            m_rv1   = (m_rw == 1);
            m_rprio = 1 - m_rw;
        end else begin
            m_rv0 = 1'b0;
            m_rv1 = 1'b0;
        end
        if (m_ww >= 0) begin
            m_mem[(m_ww == 0) ? addr0 : addr1] = (m_ww == 0) ? data0 : data1;
            m_wprio = 1 - m_ww;
        end
        if (run && clear) begin
            m_clear_left = DEPTH;
        end else if (!run) begin
            m_clear_left--;
            if (m_clear_left == 0) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_init(string name, bit expect_latency);
        int cyc;
        cyc = 0;
        for (int i = 0; i < 40 && !init_done; i++) begin
            do_cycle(1);
            cyc++;
        end
        if (expect_latency) chk(name, cyc, DEPTH);
        else chk(name, init_done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit p0, p1;
        tbl[0]  = mk(0,0,0,8'h00, 1,0,5,8'h00, 0,1,0,0,8'h00);
        tbl[1]  = mk(1,1,3,8'hA5, 0,0,0,8'h00, 1,0,0,1,8'h00);
        tbl[2]  = mk(0,0,0,8'h00, 1,0,3,8'h00, 0,1,0,0,8'h00);
        tbl[3]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 0,0,0,1,8'hA5);
        tbl[4]  = mk(1,1,7,8'h11, 0,0,0,8'h00, 1,0,0,0,8'hA5);
        tbl[5]  = mk(1,1,7,8'h3C, 1,0,7,8'h00, 1,1,0,0,8'hA5);
        tbl[6]  = mk(1,0,7,8'h00, 0,0,0,8'h00, 1,0,0,1,8'h11);
        tbl[7]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 0,0,1,0,8'h3C);
        tbl[8]  = mk(0,0,0,8'h00, 1,0,3,8'h00, 0,1,0,0,8'h3C);
        tbl[9]  = mk(1,0,3,8'h00, 1,0,7,8'h00, 1,0,0,1,8'hA5);
        tbl[10] = mk(1,0,3,8'h00, 1,0,7,8'h00, 0,1,1,0,8'hA5);
        tbl[11] = mk(1,0,3,8'h00, 1,0,7,8'h00, 1,0,0,1,8'h3C);
        tbl[12] = mk(1,0,3,8'h00, 1,0,7,8'h00, 0,1,1,0,8'hA5);
        tbl[13] = mk(1,0,3,8'h00, 1,0,7,8'h00, 1,0,0,1,8'h3C);
        tbl[14] = mk(1,0,3,8'h00, 1,0,7,8'h00, 0,1,1,0,8'hA5);
        tbl[15] = mk(0,0,0,8'h00, 0,0,0,8'h00, 0,0,0,1,8'h3C);
        tbl[16] = mk(1,1,1,8'h22, 1,1,2,8'h33, 0,1,0,0,8'h3C);
        tbl[17] = mk(1,1,1,8'h22, 1,1,4,8'h44, 1,0,0,0,8'h3C);
        tbl[18] = mk(1,0,2,8'h00, 1,0,1,8'h00, 1,0,0,0,8'h3C);
        tbl[19] = mk(0,0,0,8'h00, 1,0,1,8'h00, 0,1,1,0,8'h33);
        tbl[20] = mk(0,0,0,8'h00, 0,0,0,8'h00, 0,0,0,1,8'h22);

        // Reset state, with requests already present
        rst_n = 1'b0;
        set_idle();
        req0 = 1; we0 = 0; addr0 = 4'd5;
        model_reset();
        #7;
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_rdata", rdata, 8'h00);

        // Clear after reset release; requests during CLEAR must be ignored
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1; we0 = 1; addr0 = 4'd5; data0 = 8'hFF;
        req1 = 1; we1 = 0; addr1 = 4'd5;
        wait_init("init_latency", 1);

        // Directed vector table
        for (int i = 0; i < 21; i++) begin
            req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; data0 = tbl[i].d0;
            req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; data1 = tbl[i].d1;
            clear = 0;
            #1;
            chk($sformatf("tbl_gnt0[%0d]", i), gnt0, tbl[i].g0);
            chk($sformatf("tbl_gnt1[%0d]", i), gnt1, tbl[i].g1);
            chk($sformatf("tbl_rvalid0[%0d]", i), rvalid0, tbl[i].v0);
            chk($sformatf("tbl_rvalid1[%0d]", i), rvalid1, tbl[i].v1);
            chk($sformatf("tbl_rdata[%0d]", i), rdata, tbl[i].rd);
            do_cycle(0);
        end

        // Clear mid-traffic: that cycle's grants complete, then 16 cycles of CLEAR
        set_idle();
        req0 = 1; we0 = 0; addr0 = 4'd3;
        req1 = 1; we1 = 1; addr1 = 4'd6; data1 = 8'h77;
        clear = 1;
        #1;
        chk("clear_cycle_gnt0", gnt0, 1'b1);
        chk("clear_cycle_gnt1", gnt1, 1'b1);
        do_cycle(1);
        clear = 0;
        data1 = 8'h88;
        for (int i = 0; i < 4; i++) do_cycle(1);
        clear = 1;
        do_cycle(1);
        clear = 0;
        for (int i = 0; i < 40 && !init_done; i++) do_cycle(1);
        chk("clear_done", init_done, 1'b1);
        set_idle();
        for (int a = 0; a < DEPTH; a++) begin
            req0 = 1; we0 = 0; addr0 = AW'(a);
            do_cycle(1);
            chk("clear_zero", rdata, 8'h00);
        end
        set_idle();
        do_cycle(1);

        // Randomized traffic against the model
        p0 = 0; p1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!p0) begin
                if ($urandom_range(2) != 0) begin
                    req0 = 1; we0 = $urandom_range(1); addr0 = AW'($urandom_range(DEPTH-1));
                    data0 = DW'($urandom); p0 = 1;
                end else begin
                    req0 = 0;
                end
            end
            if (!p1) begin
                if ($urandom_range(2) != 0) begin
                    req1 = 1; we1 = $urandom_range(1); addr1 = AW'($urandom_range(DEPTH-1));
                    data1 = DW'($urandom); p1 = 1;
                end else begin
                    req1 = 0;
                end
            end
            clear = ($urandom_range(79) == 0);
            do_cycle(1);
            if (m_ww == 0 || m_rw == 0) p0 = 0;
            if (m_ww == 1 || m_rw == 1) p1 = 0;
        end
        set_idle();
        wait_init("rand_settle", 0);

        // Reset asserted during a read grant: the result is discarded
        req1 = 1; we1 = 0; addr1 = 4'd2;
        #1;
        chk("rst_mid_gnt_before", gnt1, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_gnt_after", gnt1, 1'b0);
        chk("rst_mid_init_done", init_done, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_mid_rvalid1", rvalid1, 1'b0);
        chk("rst_mid_rvalid0", rvalid0, 1'b0);
        chk("rst_mid_rdata", rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        req1 = 0;
        wait_init("rst_mid_latency", 1);
        req1 = 1; we1 = 0; addr1 = 4'd2;
        do_cycle(1);
        set_idle();
        do_cycle(1);
        chk("rst_mid_read", rdata, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width of the shared RAM.
REQ-002 Parameter DEPTH, default 3072, number of RAM words; ADDR_W = $clog2(DEPTH).
REQ-003 i_clk  input  1  single clock, all state on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_clear  input  1  one-cycle pulse, re-zero the whole RAM.
REQ-006 i_req0 / i_req1  input  1  requester N access request.
REQ-007 i_we0 / i_we1  input  1  requester N op: 1 write, 0 read.
REQ-008 i_addr0 / i_addr1  input  ADDR_W  requester N address.
REQ-009 i_data0 / i_data1  input  DATA_WIDTH  requester N write data.
REQ-010 o_gnt0 / o_gnt1  output  1  requester N request accepted this cycle.
REQ-011 o_rvalid0 / o_rvalid1  output  1  o_rdata holds requester N read result.
REQ-012 o_rdata  output  DATA_WIDTH  shared read data.
REQ-013 o_init_done  output  1  high when RAM clear complete and arbitration active.

Function
REQ-014 FSM states CLEAR and RUN; reset enters CLEAR with clear counter 0.
REQ-015 CLEAR: one RAM write per cycle of 0 at address counter, counter increments by 1; counter == DEPTH-1 writes last word and moves to RUN next cycle.
REQ-016 o_init_done = 1 only in RUN; first RUN cycle is DEPTH cycles after reset release.
REQ-017 In CLEAR, o_gnt0 and o_gnt1 are 0 and requests are ignored.
REQ-018 i_clear in RUN moves to CLEAR next cycle, counter 0; grants in the i_clear cycle still complete; i_clear in CLEAR is ignored.
REQ-019 Write port and read port are arbitrated independently; per cycle at most one write grant and one read grant.
REQ-020 Grants are combinational from req/we in RUN; a requester holds req, we, addr, data stable until gnt.
REQ-021 Per port, a single contender is granted immediately.
REQ-022 Per port, two contenders: grant the requester not granted most recently on that port; port pointer reset value favours requester 0.
REQ-023 A port's pointer updates only on a cycle in which that port grants.
REQ-024 Read latency 1: read granted in cycle T gives o_rdata and o_rvalidN = 1 in T+1, for one cycle.
REQ-025 Simultaneous write and read to the same address return the old word (read-before-write).
REQ-026 o_rvalid0 and o_rvalid1 are never high together.
REQ-027 With no read grant in T, o_rvalidN are 0 in T+1 and o_rdata holds its last value.

Reset
REQ-028 Asynchronous assertion of i_rst_n low forces CLEAR, counter 0, both pointers to requester 0, o_rvalid0/1 = 0, o_init_done = 0, o_gnt0/1 = 0.
REQ-029 In-flight read results are discarded on reset; RAM contents are not reset directly but are re-zeroed by CLEAR.
REQ-030 o_rdata is 0 from reset until the first read completes.

Structure
REQ-031 Package ram_arb_pkg holds the state enum (CLEAR, RUN) and the requester-id constants REQ0 = 0, REQ1 = 1.
REQ-032 Storage is one instance of the existing RAM_param module, DATA_WIDTH and DEPTH passed through.
REQ-033 Arbitration, the clear counter, the FSM and the rvalid tag register reside in ram_arbiter.

Verification
REQ-034 Release reset, DEPTH=16 -> o_init_done rises exactly 16 cycles later; read of addr 5 returns 0.
REQ-035 Req0 write addr 3 = 0xA5, next cycle req1 read addr 3 -> o_gnt1 same cycle, o_rvalid1 next cycle, o_rdata = 0xA5.
REQ-036 Both requesters read continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; o_rvalid alternates one cycle later.
REQ-037 Same cycle req0 write addr 7 = 0x3C, req1 read addr 7 (old 0x11) -> both granted, o_rdata = 0x11; subsequent read gives 0x3C.
REQ-038 i_clear mid-traffic, DEPTH=16 -> o_init_done low and grants 0 for 16 cycles; afterwards all reads return 0.
REQ-039 i_rst_n low during a read grant cycle -> no o_rvalid next cycle; CLEAR restarts at address 0.
